dec_ptv_iter: RTL

- Iterative, handshaked physical-to-virtual decoder over the full SCB tree.
- Walks all STAGES = log2(BITMAP) tree levels, evaluating SPC levels per clock with the existing dec_node cell.
- Assembles the decoded address one bit per level.
- Sits between the allocator SCB array and the translation consumer; replaces a combinational chain of stage decoders, so deep bitmaps meet timing.

---
 rtl/dec_ptv_iter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dec_ptv_iter.sv
// Iterative physical-to-virtual decoder walking the SCB tree SPC levels per clock.
// Optional one-hot path check enabled by DEC_PTV_ITER_ONEHOT_CHK_EN (adds o_rsp_err).

module dec_node (
   input  logic actv,
   input  logic scb,
   input  logic inv,
   output logic hit,
   output logic left,
   output logic right
);
   // A set SCB bit marks a split node: it reports a hit and opens both subtrees.
   // A clear bit follows the address bit (inv) into exactly one child.
   assign hit   = actv & scb;
   assign left  = actv & (scb | ~inv);
   assign right = actv & (scb | inv);
endmodule

// state | meaning
// IDLE  | waiting for a request, ready asserted
// WALK  | evaluating SPC tree levels per clock
// DONE  | response valid, holding o_vaddr until i_rsp_rdy
module dec_ptv_iter #(
   parameter int BITMAP = 128,
   parameter int SPC    = 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_req_vld,
   output logic                                 o_req_rdy,
   input  logic [$clog2(BITMAP)-1:0]            i_paddr,
   input  logic [$clog2(BITMAP)*(BITMAP/2)-1:0] i_scb,
   input  logic                                 i_abort,
   output logic                                 o_rsp_vld,
   input  logic                                 i_rsp_rdy,
   output logic [$clog2(BITMAP)-1:0]            o_vaddr,
`ifdef DEC_PTV_ITER_ONEHOT_CHK_EN
   output logic                                 o_rsp_err,
`endif
   output logic                                 o_busy
);
   localparam int STAGES   = $clog2(BITMAP);
   localparam int NODES    = BITMAP / 2;
   localparam int ADDR_W   = $clog2(BITMAP);
   localparam int WALK_CYC = STAGES / SPC;
   localparam int CNT_W    = (WALK_CYC > 1) ? $clog2(WALK_CYC) : 1;
   localparam int NCNT     = 2 ** CNT_W;
`ifdef DEC_PTV_ITER_ONEHOT_CHK_EN
   localparam int AW       = BITMAP;
`else
   localparam int AW       = NODES;
`endif

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t                     state_q, state_nxt;
   logic [CNT_W-1:0]           cnt_q;
   logic [AW-1:0]              actv_q;
   logic [ADDR_W-1:0]          vaddr_q, vaddr_nxt;
   logic [ADDR_W-1:0]          paddr_q;
   logic [STAGES*NODES-1:0]    scb_q;
   logic                       accept;
   logic                       last_cyc;

   logic [AW-1:0] chain    [SPC+1];
   logic [AW-1:0] lvl_actv [SPC][NCNT];
   logic          lvl_hit  [SPC][NCNT];
   logic          hit_sel  [SPC];

   assign chain[0] = actv_q;

   // Chain step k can only ever be level j*SPC+k; build each candidate and mux by cnt.
   for (genvar k = 0; k < SPC; k++) begin : g_step
      for (genvar j = 0; j < NCNT; j++) begin : g_cand
         if (j < WALK_CYC) begin : g_lvl
            localparam int S     = j * SPC + k;
            localparam int GW    = 2 ** S;
            localparam int SEL_W = (S == STAGES - 1) ? 1 : STAGES - 1 - S;

            logic [SEL_W-1:0] sel;
            logic [GW-1:0]    grp;
            logic [GW-1:0]    hits;
            logic [GW-1:0]    lft;
            logic [GW-1:0]    rgt;

            if (S == STAGES - 1) begin : g_top
               assign sel = '0;
            end else begin : g_sub
               assign sel = paddr_q[ADDR_W-1:S+1];
            end

            assign grp = GW'(scb_q[S*NODES +: NODES] >> (32'(sel) * GW));

            for (genvar i = 0; i < GW; i++) begin : g_node
               dec_node u_node (
                  .actv  (chain[k][i]),
                  .scb   (grp[i]),
                  .inv   (paddr_q[S]),
                  .hit   (hits[i]),
                  .left  (lft[i]),
                  .right (rgt[i])
               );
            end

            assign lvl_hit[k][j]  = |hits;
            assign lvl_actv[k][j] = AW'({rgt, lft});
         end else begin : g_pad
            assign lvl_hit[k][j]  = 1'b0;
            assign lvl_actv[k][j] = '0;
         end
      end

      assign chain[k+1] = lvl_actv[k][cnt_q];
      assign hit_sel[k] = lvl_hit[k][cnt_q];
   end

   always_comb begin
      vaddr_nxt = vaddr_q;
      for (int k = 0; k < SPC; k++) begin
         vaddr_nxt = vaddr_nxt | (ADDR_W'(hit_sel[k]) << (32'(cnt_q) * SPC + k));
      end
   end

   assign last_cyc  = (cnt_q == CNT_W'(WALK_CYC - 1));
   assign o_req_rdy = ~i_rst & ((state_q == IDLE) | ((state_q == DONE) & i_rsp_rdy));
   assign accept    = i_req_vld & o_req_rdy;

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: if (accept) state_nxt = WALK;
         WALK: begin
            if (i_abort)       state_nxt = IDLE;
            else if (last_cyc) state_nxt = DONE;
         end
         DONE: begin
            if (accept)         state_nxt = WALK;
            else if (i_rsp_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DEC_PTV_ITER_ONEHOT_CHK_EN
   logic err_q;
   logic step_bad;

   always_comb begin
      step_bad = 1'b0;
      for (int k = 1; k <= SPC; k++) begin
         if ((chain[k] == '0) || ((chain[k] & (chain[k] - AW'(1))) != '0)) step_bad = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)                                err_q <= 1'b0;
      else if (accept)                          err_q <= 1'b0;
      else if ((state_q == WALK) && !i_abort)   err_q <= err_q | step_bad;
   end

   assign o_rsp_err = err_q;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         actv_q  <= '0;
         vaddr_q <= '0;
         paddr_q <= '0;
         scb_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (accept) begin
            paddr_q <= i_paddr;
            scb_q   <= i_scb;
            actv_q  <= AW'(1);
            cnt_q   <= '0;
            vaddr_q <= '0;
         end else if ((state_q == WALK) && !i_abort) begin
            actv_q  <= chain[SPC];
            vaddr_q <= vaddr_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign o_rsp_vld = (state_q == DONE);
   assign o_busy    = (state_q == WALK);
   assign o_vaddr   = vaddr_q;

endmodule
